// File: rtl/ex_wb_ctrl.sv
// EX-to-writeback controller: ALU results retire in one cycle, loads go through a
// memory request/response handshake guarded by a per-load timeout counter.
module ex_wb_ctrl #(
    parameter int DW         = 32,
    parameter int RW         = 5,
    parameter int LD_TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ex_valid_i,
    output logic          ex_ready_o,
    input  logic          ex_is_load_i,
    input  logic [RW-1:0] ex_rd_i,
    input  logic [DW-1:0] ex_res_i,
    input  logic [DW-1:0] ex_addr_i,
    output logic          mem_req_o,
    output logic [DW-1:0] mem_addr_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          wb_valid_o,
    output logic [RW-1:0] wb_rd_o,
    output logic [DW-1:0] wb_wbv_o,
    output logic          ld_timeout_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(LD_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [DW-1:0] addr_q, addr_d;
    logic          wb_valid_q, wb_valid_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic [DW-1:0] wb_wbv_q, wb_wbv_d;
    logic          ld_timeout_q, ld_timeout_d;
    logic          cnt_expired;

    assign ex_ready_o   = (state_q == S_IDLE);
    assign mem_req_o    = (state_q == S_REQ);
    assign mem_addr_o   = addr_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_wbv_o     = wb_wbv_q;
    assign ld_timeout_o = ld_timeout_q;

    assign cnt_expired = (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        addr_d       = addr_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_wbv_d     = wb_wbv_q;
        ld_timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ex_valid_i) begin
                    if (ex_is_load_i) begin
                        state_d = S_REQ;
                        cnt_d   = 8'd0;
                        rd_d    = ex_rd_i;
                        addr_d  = ex_addr_i;
                    end else if (ex_rd_i != '0) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd_i;
                        wb_wbv_d   = ex_res_i;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                // An expiring counter takes priority over a grant arriving in the same cycle.
                if (cnt_expired) begin
                    state_d      = S_IDLE;
                    ld_timeout_d = 1'b1;
                    if (rd_q != '0) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_wbv_d   = '0;
                    end
                end else if (mem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid_i) begin
                    state_d = S_IDLE;
                    if (rd_q != '0) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_wbv_d   = mem_rdata_i;
                    end
                end else if (cnt_expired) begin
                    state_d      = S_IDLE;
                    ld_timeout_d = 1'b1;
                    if (rd_q != '0) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_wbv_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            rd_q         <= '0;
            addr_q       <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_wbv_q     <= '0;
            ld_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_wbv_q     <= wb_wbv_d;
            ld_timeout_q <= ld_timeout_d;
        end
    end

endmodule

// File: tb/tb_ex_wb_ctrl.sv
// Directed bench for ex_wb_ctrl: a default instance plus a short-timeout instance
// sharing the same stimulus; each scenario checks only the instance it targets.
module tb_ex_wb_ctrl;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ex_valid, ex_is_load;
    logic [RW-1:0] ex_rd;
    logic [DW-1:0] ex_res, ex_addr;
    logic          mem_gnt, mem_rvalid;
    logic [DW-1:0] mem_rdata;

    logic          ex_ready, mem_req, wb_valid, ld_timeout;
    logic [DW-1:0] mem_addr, wb_wbv;
    logic [RW-1:0] wb_rd;
    logic          ex_ready4, mem_req4, wb_valid4, ld_timeout4;
    logic [DW-1:0] mem_addr4, wb_wbv4;
    logic [RW-1:0] wb_rd4;

    int tests = 0;
    int fails = 0;

    logic [RW-1:0] b2bRd  [3] = '{5'd1, 5'd2, 5'd4};
    logic [DW-1:0] b2bRes [3] = '{32'h11, 32'h22, 32'h44};

    always #5 clk = ~clk;

    ex_wb_ctrl #(.DW(DW), .RW(RW), .LD_TIMEOUT(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
        .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd), .ex_res_i(ex_res), .ex_addr_i(ex_addr),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .wb_valid_o(wb_valid),
        .wb_rd_o(wb_rd), .wb_wbv_o(wb_wbv), .ld_timeout_o(ld_timeout)
    );

    ex_wb_ctrl #(.DW(DW), .RW(RW), .LD_TIMEOUT(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .ex_valid_i(ex_valid), .ex_ready_o(ex_ready4),
        .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd), .ex_res_i(ex_res), .ex_addr_i(ex_addr),
        .mem_req_o(mem_req4), .mem_addr_o(mem_addr4), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .wb_valid_o(wb_valid4),
        .wb_rd_o(wb_rd4), .wb_wbv_o(wb_wbv4), .ld_timeout_o(ld_timeout4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_res = '0; ex_addr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic isLoad, input logic [RW-1:0] rd, input logic [DW-1:0] val);
        ex_valid = 1'b1; ex_is_load = isLoad; ex_rd = rd;
        ex_res = val; ex_addr = val;
    endtask

    task automatic test_reset();
        idle_inputs();
        #3 rst_n = 1'b0;
        #1;
        tests++; if (ex_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b want 1", ex_ready); end
        tests++; if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); end
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_wb_valid: got %b want 0", wb_valid); end
        tests++; if (wb_rd !== 5'd0) begin fails++; $display("[TB] FAIL reset_wb_rd: got %0d want 0", wb_rd); end
        tests++; if (wb_wbv !== 32'd0) begin fails++; $display("[TB] FAIL reset_wb_wbv: got %h want 0", wb_wbv); end
        tests++; if (ld_timeout !== 1'b0) begin fails++; $display("[TB] FAIL reset_ld_timeout: got %b want 0", ld_timeout); end
        tests++; if (ex_ready4 !== 1'b1 || mem_req4 !== 1'b0) begin fails++; $display("[TB] FAIL reset_dut4: ready %b req %b want 1 0", ex_ready4, mem_req4); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        issue(1'b0, 5'd3, 32'hA5);
        step();
        tests++; if (wb_valid !== 1'b1) begin fails++; $display("[TB] FAIL alu_valid: got %b want 1", wb_valid); end
        tests++; if (wb_rd !== 5'd3) begin fails++; $display("[TB] FAIL alu_rd: got %0d want 3", wb_rd); end
        tests++; if (wb_wbv !== 32'hA5) begin fails++; $display("[TB] FAIL alu_wbv: got %h want a5", wb_wbv); end
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, b2bRd[i], b2bRes[i]);
            step();
            tests++; if (wb_valid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_valid[%0d]: got %b want 1", i, wb_valid); end
            tests++; if (wb_rd !== b2bRd[i] || wb_wbv !== b2bRes[i]) begin fails++; $display("[TB] FAIL b2b_data[%0d]: got rd %0d val %h want rd %0d val %h", i, wb_rd, wb_wbv, b2bRd[i], b2bRes[i]); end
        end
        ex_valid = 1'b0;
        step();
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL alu_pulse: got %b want 0", wb_valid); end
        tests++; if (wb_rd !== 5'd4 || wb_wbv !== 32'h44) begin fails++; $display("[TB] FAIL alu_hold: got rd %0d val %h want rd 4 val 44", wb_rd, wb_wbv); end
    endtask

    task automatic test_load();
        do_reset();
        issue(1'b1, 5'd7, 32'h100);
        tests++; if (ex_ready !== 1'b1) begin fails++; $display("[TB] FAIL load_ready_idle: got %b want 1", ex_ready); end
        step();
        idle_inputs();
        ex_addr = 32'hFFF;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin fails++; $display("[TB] FAIL load_req0: got req %b addr %h want 1 100", mem_req, mem_addr); end
        tests++; if (ex_ready !== 1'b0) begin fails++; $display("[TB] FAIL load_ready_req: got %b want 0", ex_ready); end
        step();
        mem_rvalid = 1'b0;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin fails++; $display("[TB] FAIL load_req1: got req %b addr %h want 1 100", mem_req, mem_addr); end
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL load_rvalid_in_req: got wb_valid %b want 0", wb_valid); end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        tests++; if (mem_req !== 1'b0 || ex_ready !== 1'b0) begin fails++; $display("[TB] FAIL load_wait: got req %b ready %b want 0 0", mem_req, ex_ready); end
        for (int i = 0; i < 2; i++) begin
            step();
            tests++; if (wb_valid !== 1'b0 || ex_ready !== 1'b0) begin fails++; $display("[TB] FAIL load_wait_hold[%0d]: got valid %b ready %b want 0 0", i, wb_valid, ex_ready); end
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
        step();
        mem_rvalid = 1'b0;
        tests++; if (wb_valid !== 1'b1) begin fails++; $display("[TB] FAIL load_wb_valid: got %b want 1", wb_valid); end
        tests++; if (wb_rd !== 5'd7 || wb_wbv !== 32'hDEAD) begin fails++; $display("[TB] FAIL load_wb_data: got rd %0d val %h want rd 7 val dead", wb_rd, wb_wbv); end
        tests++; if (ld_timeout !== 1'b0 || ex_ready !== 1'b1) begin fails++; $display("[TB] FAIL load_done: got tmo %b ready %b want 0 1", ld_timeout, ex_ready); end
        step();
        tests++; if (wb_valid !== 1'b0 || wb_wbv !== 32'hDEAD) begin fails++; $display("[TB] FAIL load_after: got valid %b val %h want 0 dead", wb_valid, wb_wbv); end
    endtask

    task automatic test_timeout();
        do_reset();
        issue(1'b1, 5'd9, 32'h40);
        step();
        ex_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++; if (mem_req4 !== 1'b1 || ld_timeout4 !== 1'b0 || wb_valid4 !== 1'b0) begin fails++; $display("[TB] FAIL tmo_pending[%0d]: got req %b tmo %b valid %b want 1 0 0", k, mem_req4, ld_timeout4, wb_valid4); end
            if (k == 3) mem_gnt = 1'b1;
            step();
        end
        mem_gnt = 1'b0;
        tests++; if (wb_valid4 !== 1'b1 || ld_timeout4 !== 1'b1) begin fails++; $display("[TB] FAIL tmo_pulse: got valid %b tmo %b want 1 1", wb_valid4, ld_timeout4); end
        tests++; if (wb_wbv4 !== 32'd0 || wb_rd4 !== 5'd9) begin fails++; $display("[TB] FAIL tmo_data: got rd %0d val %h want rd 9 val 0", wb_rd4, wb_wbv4); end
        tests++; if (mem_req4 !== 1'b0 || ex_ready4 !== 1'b1) begin fails++; $display("[TB] FAIL tmo_idle: got req %b ready %b want 0 1", mem_req4, ex_ready4); end
        step();
        tests++; if (ld_timeout4 !== 1'b0 || wb_valid4 !== 1'b0) begin fails++; $display("[TB] FAIL tmo_single: got tmo %b valid %b want 0 0", ld_timeout4, wb_valid4); end
    endtask

    task automatic test_race();
        do_reset();
        issue(1'b1, 5'd12, 32'h80);
        step();
        ex_valid = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        step();
        tests++; if (ld_timeout4 !== 1'b0 || wb_valid4 !== 1'b0) begin fails++; $display("[TB] FAIL race_pre: got tmo %b valid %b want 0 0", ld_timeout4, wb_valid4); end
        mem_rvalid = 1'b1; mem_rdata = 32'hBEEF;
        step();
        mem_rvalid = 1'b0;
        tests++; if (wb_valid4 !== 1'b1 || ld_timeout4 !== 1'b0) begin fails++; $display("[TB] FAIL race_pulse: got valid %b tmo %b want 1 0", wb_valid4, ld_timeout4); end
        tests++; if (wb_wbv4 !== 32'hBEEF || wb_rd4 !== 5'd12) begin fails++; $display("[TB] FAIL race_data: got rd %0d val %h want rd 12 val beef", wb_rd4, wb_wbv4); end
    endtask

    task automatic test_rd_zero();
        do_reset();
        issue(1'b0, 5'd5, 32'h77);
        step();
        tests++; if (wb_valid !== 1'b1) begin fails++; $display("[TB] FAIL rd0_setup: got %b want 1", wb_valid); end
        issue(1'b0, 5'd0, 32'h55);
        step();
        tests++; if (wb_valid !== 1'b0 || wb_rd !== 5'd5 || wb_wbv !== 32'h77) begin fails++; $display("[TB] FAIL rd0_alu: got valid %b rd %0d val %h want 0 5 77", wb_valid, wb_rd, wb_wbv); end
        ex_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99;
        step();
        mem_rvalid = 1'b0;
        tests++; if (wb_valid !== 1'b0 || wb_wbv !== 32'h77) begin fails++; $display("[TB] FAIL rvalid_idle: got valid %b val %h want 0 77", wb_valid, wb_wbv); end
        issue(1'b1, 5'd0, 32'h300);
        step();
        ex_valid = 1'b0;
        tests++; if (mem_req4 !== 1'b1 || mem_addr4 !== 32'h300) begin fails++; $display("[TB] FAIL rd0_load_req: got req %b addr %h want 1 300", mem_req4, mem_addr4); end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        step();
        step();
        tests++; if (ld_timeout4 !== 1'b1 || wb_valid4 !== 1'b0 || ex_ready4 !== 1'b1) begin fails++; $display("[TB] FAIL rd0_load_tmo: got tmo %b valid %b ready %b want 1 0 1", ld_timeout4, wb_valid4, ex_ready4); end
        tests++; if (wb_wbv4 !== 32'h77 || wb_rd4 !== 5'd5) begin fails++; $display("[TB] FAIL rd0_hold: got rd %0d val %h want rd 5 val 77", wb_rd4, wb_wbv4); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        issue(1'b0, 5'd1, 32'hABCD);
        step();
        issue(1'b1, 5'd6, 32'h200);
        step();
        ex_valid = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        tests++; if (mem_req !== 1'b0 || ex_ready !== 1'b0 || wb_wbv !== 32'hABCD) begin fails++; $display("[TB] FAIL mid_wait_pre: got req %b ready %b val %h want 0 0 abcd", mem_req, ex_ready, wb_wbv); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (ex_ready !== 1'b1 || wb_valid !== 1'b0 || ld_timeout !== 1'b0) begin fails++; $display("[TB] FAIL mid_wait_async: got ready %b valid %b tmo %b want 1 0 0", ex_ready, wb_valid, ld_timeout); end
        tests++; if (wb_wbv !== 32'd0 || wb_rd !== 5'd0) begin fails++; $display("[TB] FAIL mid_wait_clear: got rd %0d val %h want 0 0", wb_rd, wb_wbv); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
        step();
        mem_rvalid = 1'b0;
        tests++; if (wb_valid !== 1'b0 || wb_wbv !== 32'd0) begin fails++; $display("[TB] FAIL late_rvalid: got valid %b val %h want 0 0", wb_valid, wb_wbv); end
        issue(1'b0, 5'd2, 32'h1234);
        step();
        ex_valid = 1'b0;
        tests++; if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_wbv !== 32'h1234) begin fails++; $display("[TB] FAIL post_reset_alu: got valid %b rd %0d val %h want 1 2 1234", wb_valid, wb_rd, wb_wbv); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_timeout();
        test_race();
        test_rd_zero();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_wb_ctrl.md
EX_WB_CTRL -- requirements
Module: ex_wb_ctrl

Interface
REQ-001 Parameter DW, default 32, data/address width.
REQ-002 Parameter RW, default 5, destination register index width.
REQ-003 Parameter LD_TIMEOUT, default 16, max cycles from load issue to response; legal range 2..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ex_valid  input  1  EX stage presents an instruction.
REQ-007 ex_ready  output  1  controller accepts the EX instruction this cycle.
REQ-008 ex_is_load  input  1  1 = load, 0 = ALU result.
REQ-009 ex_rd  input  RW  destination register index.
REQ-010 ex_res  input  DW  ALU result.
REQ-011 ex_addr  input  DW  load address.
REQ-012 mem_req  output  1  load request to memory.
REQ-013 mem_addr  output  DW  load address to memory.
REQ-014 mem_gnt  input  1  memory accepts the request.
REQ-015 mem_rvalid  input  1  load data valid.
REQ-016 mem_rdata  input  DW  load data.
REQ-017 wb_valid  output  1  one-cycle writeback strobe.
REQ-018 wb_rd  output  RW  writeback register index.
REQ-019 wb_wbv  output  DW  writeback value.
REQ-020 ld_timeout  output  1  one-cycle pulse: load aborted on timeout.

Function
REQ-021 Three states: IDLE, REQ, WAIT; ex_ready SHALL be 1 exactly when state is IDLE (combinational, not dependent on ex_valid).
REQ-022 A transfer occurs on a rising edge with ex_valid=1 and ex_ready=1.
REQ-023 ALU transfer (ex_is_load=0): next cycle wb_valid=1, wb_wbv=ex_res, wb_rd=ex_rd; state stays IDLE; back-to-back ALU transfers SHALL give one wb_valid per cycle.
REQ-024 Load transfer: capture ex_rd and ex_addr, go to REQ, no writeback that cycle.
REQ-025 REQ: mem_req=1, mem_addr=captured address (stable until granted); on mem_gnt=1 go to WAIT.
REQ-026 mem_req SHALL be 0 in IDLE and WAIT; mem_addr is don't-care when mem_req=0.
REQ-027 WAIT: on mem_rvalid=1, next cycle wb_valid=1, wb_wbv=mem_rdata, wb_rd=captured rd; state to IDLE.
REQ-028 mem_rvalid while in IDLE or REQ SHALL be ignored.
REQ-029 An 8-bit load counter SHALL clear on load transfer and increment every cycle in REQ or WAIT.
REQ-030 If counter reaches LD_TIMEOUT-1 in REQ or WAIT without completion, next cycle: wb_valid=1, wb_wbv=0, wb_rd=captured rd, ld_timeout=1; state to IDLE; mem_req deasserted.
REQ-031 mem_rvalid and timeout in the same WAIT cycle: response wins, ld_timeout stays 0.
REQ-032 mem_gnt and timeout in the same REQ cycle: timeout wins.
REQ-033 Destination index 0: wb_valid SHALL stay 0 for that instruction; load still issued and sequenced normally; ld_timeout still pulses.
REQ-034 wb_valid and ld_timeout are single-cycle pulses; wb_rd and wb_wbv SHALL hold last written value while wb_valid=0.
REQ-035 Latency: ALU 1 cycle; load = cycles to grant + cycles to response + 1.

Reset
REQ-036 rst_n=0 SHALL immediately force state IDLE, counter 0, wb_valid=0, wb_rd=0, wb_wbv=0, ld_timeout=0, mem_req=0.
REQ-037 Reset during REQ/WAIT SHALL abandon the load with no writeback; a late mem_rvalid after reset SHALL be ignored.
REQ-038 First transfer accepted on first rising edge with rst_n=1.

Verification
REQ-039 ALU: ex_valid=1, is_load=0, rd=3, res=0xA5 -> next cycle wb_valid=1, wb_rd=3, wb_wbv=0xA5; three back-to-back -> three consecutive strobes.
REQ-040 Load: rd=7, addr=0x100, gnt after 2 cycles, rvalid+rdata=0xDEAD 3 cycles later -> mem_addr=0x100 during REQ, ex_ready=0 throughout, wb_wbv=0xDEAD, wb_rd=7 one cycle after rvalid.
REQ-041 Timeout: LD_TIMEOUT=4, gnt never -> after 4 cycles wb_valid=1, wb_wbv=0, ld_timeout=1, mem_req=0, ex_ready=1.
REQ-042 Race: rvalid on the final counter cycle -> rdata written back, ld_timeout=0.
REQ-043 rd=0: ALU and load with rd=0 -> no wb_valid; load still requests memory and returns to IDLE.
REQ-044 Reset mid-WAIT, then rvalid -> outputs zero, no wb_valid, next ALU instruction writes back normally.
